// File: rtl/sddac_ctrl.sv
// Sample-rate scheduler and soft-mute controller feeding the sigma-delta DAC modulator.
// A small PCM FIFO is drained one sample every OSR clocks; mute ramps the output linearly to zero.
module sddac_ctrl #(
   parameter int W         = 16,
   parameter int OSR       = 64,
   parameter int DEPTH     = 4,
   parameter int RAMP_STEP = 256
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       s_valid,
   input  logic [W-1:0]               s_data,
   output logic                       s_ready,
   input  logic                       enable,
   input  logic                       mute,
   output logic signed [W-1:0]        dac_sig,
   output logic                       sample_tick,
   output logic                       underrun,
   output logic [1:0]                 state,
   output logic [$clog2(DEPTH):0]     fifo_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(OSR);
   localparam logic signed [W:0] STEP = (W+1)'(RAMP_STEP);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      RAMP  = 2'd2,
      MUTED = 2'd3
   } state_t;

   state_t          state_q;
   state_t          state_n;
   state_t          eff_state;
   logic [CW-1:0]   cnt;
   logic            tick;

   logic [W-1:0]    mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [LW-1:0]   level;
   logic            push;
   logic            pop_req;
   logic            do_pop;
   logic            fifo_empty;

   logic signed [W-1:0] dac_n;
   logic                under_n;
   logic signed [W:0]   dac_ext;
   logic signed [W:0]   dac_mag;
   logic signed [W:0]   dac_ramped;

   assign state      = state_q;
   assign fifo_level = level;
   assign s_ready    = (level != LW'(DEPTH));
   assign fifo_empty = (level == '0);
   assign push       = s_valid && s_ready;
   assign tick       = (state_q != IDLE) && (cnt == CW'(OSR - 1));
   assign do_pop     = pop_req && enable;

   // Ramp arithmetic in W+1 bits so the magnitude of the most negative sample is representable.
   assign dac_ext    = {dac_sig[W-1], dac_sig};
   assign dac_mag    = dac_ext[W] ? -dac_ext : dac_ext;
   assign dac_ramped = dac_ext[W] ? (dac_ext + STEP) : (dac_ext - STEP);

   // Mode changes take effect in the same cycle, so a coincident tick follows the new mode's rule.
   always_comb begin
      eff_state = state_q;
      if (state_q == RUN && mute)
         eff_state = RAMP;
      else if ((state_q == RAMP || state_q == MUTED) && !mute)
         eff_state = RUN;

      state_n = eff_state;
      dac_n   = dac_sig;
      under_n = underrun;
      pop_req = 1'b0;

      if (tick) begin
         unique case (eff_state)
            RUN: begin
               if (!fifo_empty) begin
                  pop_req = 1'b1;
                  dac_n   = mem[rd_ptr];
               end else begin
                  under_n = 1'b1;
               end
            end
            RAMP: begin
               pop_req = !fifo_empty;
               if (dac_mag <= STEP) begin
                  dac_n   = '0;
                  state_n = MUTED;
               end else begin
                  dac_n = dac_ramped[W-1:0];
               end
            end
            MUTED: begin
               pop_req = !fifo_empty;
               dac_n   = '0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= s_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         unique case ({push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         dac_sig     <= '0;
         sample_tick <= 1'b0;
         underrun    <= 1'b0;
         cnt         <= '0;
      end else if (!enable) begin
         state_q     <= IDLE;
         dac_sig     <= '0;
         sample_tick <= 1'b0;
         underrun    <= 1'b0;
         cnt         <= '0;
      end else if (state_q == IDLE) begin
         state_q     <= mute ? MUTED : RUN;
         sample_tick <= 1'b0;
         cnt         <= '0;
      end else begin
         state_q     <= state_n;
         dac_sig     <= dac_n;
         underrun    <= under_n;
         sample_tick <= tick;
         cnt         <= tick ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: tb/tb_sddac_ctrl.sv
// Randomized and directed bench for sddac_ctrl against a queue-based behavioural model.
// Directed phases pin the documented ramp values, tick latency and underrun behaviour.
module tb_sddac_ctrl;

   localparam int W     = 16;
   localparam int OSR   = 4;
   localparam int DEPTH = 4;
   localparam int STEP  = 256;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                s_valid;
   logic [W-1:0]        s_data;
   logic                s_ready;
   logic                enable;
   logic                mute;
   logic signed [W-1:0] dac_sig;
   logic                sample_tick;
   logic                underrun;
   logic [1:0]          state;
   logic [2:0]          fifo_level;

   int n_checks = 0;
   int n_fail   = 0;

   // behavioural model: 0=IDLE 1=RUN 2=RAMP 3=MUTED
   int m_q[$];
   int m_state, m_dac, m_cnt;
   bit m_tick, m_under;

   always #5 clk = ~clk;

   sddac_ctrl #(.W(W), .OSR(OSR), .DEPTH(DEPTH), .RAMP_STEP(STEP)) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .enable(enable), .mute(mute), .dac_sig(dac_sig), .sample_tick(sample_tick),
      .underrun(underrun), .state(state), .fifo_level(fifo_level)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      bit push, popped;
      int head, mode;
      if (!rst_n) begin
         m_q.delete();
         m_state = 0; m_dac = 0; m_cnt = 0; m_tick = 0; m_under = 0;
         return;
      end
      push   = s_valid && (m_q.size() < DEPTH);
      popped = 0;
      head   = (m_q.size() > 0) ? m_q[0] : 0;
      m_tick = 0;
      if (!enable) begin
         m_state = 0; m_dac = 0; m_cnt = 0; m_under = 0;
      end else if (m_state == 0) begin
         m_state = mute ? 3 : 1;
         m_cnt   = 0;
      end else begin
         m_tick = (m_cnt == OSR - 1);
         m_cnt  = (m_cnt + 1) % OSR;
         mode   = m_state;
         if (mute && mode == 1) mode = 2;
         if (!mute && mode != 1) mode = 1;
         if (m_tick) begin
            popped = (m_q.size() > 0);
            if (mode == 1) begin
               if (popped) m_dac = head;
               else m_under = 1;
            end else if (mode == 2) begin
               if ((m_dac < 0 ? -m_dac : m_dac) <= STEP) begin
                  m_dac = 0;
                  mode  = 3;
               end else begin
                  m_dac = (m_dac > 0) ? m_dac - STEP : m_dac + STEP;
               end
            end else begin
               m_dac = 0;
            end
         end
         m_state = mode;
      end
      if (popped) void'(m_q.pop_front());
      if (push) m_q.push_back(int'($signed(s_data)));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check("dac_sig", dac_sig, m_dac);
      check("sample_tick", sample_tick, m_tick);
      check("underrun", underrun, m_under);
      check("state", state, m_state);
      check("fifo_level", fifo_level, m_q.size());
      check("s_ready", s_ready, m_q.size() != DEPTH);
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      do begin
         cycle();
         n++;
      end while (!sample_tick && n < 3 * OSR);
      check("tick_timeout", sample_tick, 1);
   endtask

   task automatic push_one(input int d);
      s_valid = 1'b1;
      s_data  = W'(d);
      cycle();
      s_valid = 1'b0;
   endtask

   initial begin
      int n;
      rst_n = 1'b0; s_valid = 1'b0; s_data = '0; enable = 1'b0; mute = 1'b0;
      repeat (3) cycle();
      check("reset_level", fifo_level, 0);
      check("reset_state", state, 0);
      rst_n = 1'b1;

      // prefill in IDLE, then run cadence
      push_one(1000);
      push_one(2000);
      cycle();
      check("prefill_level", fifo_level, 2);
      check("prefill_ready", s_ready, 1);
      check("prefill_dac", dac_sig, 0);
      push_one(-3000);
      enable = 1'b1;
      cycle();
      wait_tick(n);
      check("first_tick_lat", n, OSR);
      check("tick1_dac", dac_sig, 1000);
      check("tick1_level", fifo_level, 2);
      wait_tick(n);
      check("tick2_lat", n, OSR);
      check("tick2_dac", dac_sig, 2000);
      wait_tick(n);
      check("tick3_dac", dac_sig, -3000);
      check("tick3_level", fifo_level, 0);
      wait_tick(n);
      check("underrun_set", underrun, 1);
      check("underrun_hold", dac_sig, -3000);

      // hold s_valid through fill and a pop cycle
      s_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         s_data = W'(100 * (i + 1));
         cycle();
      end
      s_valid = 1'b0;
      check("underrun_sticky", underrun, 1);
      enable = 1'b0;
      cycle();
      check("underrun_clear", underrun, 0);
      check("disable_dac", dac_sig, 0);

      // mute ramp from 600, then -32768 boundary
      rst_n = 1'b0; cycle(); rst_n = 1'b1;
      push_one(600);
      enable = 1'b1;
      cycle();
      wait_tick(n);
      check("ramp_load", dac_sig, 600);
      mute = 1'b1;
      wait_tick(n);
      check("ramp1", dac_sig, 344);
      check("ramp1_state", state, 2);
      wait_tick(n);
      check("ramp2", dac_sig, 88);
      wait_tick(n);
      check("ramp3", dac_sig, 0);
      check("ramp3_state", state, 3);
      check("ramp_no_underrun", underrun, 0);
      mute = 1'b0;
      push_one(-32768);
      wait_tick(n);
      check("unmute_load", dac_sig, -32768);
      check("unmute_state", state, 1);
      mute = 1'b1;
      wait_tick(n);
      check("ramp_min", dac_sig, -32512);
      mute = 1'b0;

      // reset mid-run discards FIFO
      enable = 1'b0; cycle();
      push_one(11); push_one(22); push_one(33);
      enable = 1'b1;
      cycle(); cycle();
      check("midrun_level", fifo_level, 3);
      check("midrun_state", state, 1);
      rst_n = 1'b0; cycle(); rst_n = 1'b1;
      check("rst_level", fifo_level, 0);
      check("rst_state", state, 0);
      check("rst_dac", dac_sig, 0);
      check("rst_tick", sample_tick, 0);

      // randomized traffic against the model
      enable = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         rst_n   = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 59) == 0) enable = ~enable;
         if ($urandom_range(0, 29) == 0) mute = ~mute;
         s_valid = ($urandom_range(0, 9) < 3);
         case ($urandom_range(0, 9))
            0:       s_data = 16'h8000;
            1:       s_data = 16'h7fff;
            2:       s_data = W'($urandom_range(0, 600) - 300);
            default: s_data = W'($urandom());
         endcase
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
